// File: rtl/pem_counter_bank.sv
// ---------------------------------------------------------------------------
// pem_counter_bank
// PE-memory activity counter bank. Per-channel increment pulses from the
// pem_load / pem_store datapaths are folded into four live event counters
// (load inst, load ack, store inst, store ack) and two in-flight depth
// counters. The register interface can take an atomic snapshot of the event
// counters and optionally clear them in the same cycle.
//
// Ports
//   clk, s_rst_n                 clock, asynchronous active-low reset
//   ld_inst_inc, ld_ack_inc      per-channel load issue / acknowledge pulses
//   st_inst_inc, st_ack_inc      per-channel store issue / acknowledge pulses
//   clr                          clear event counters and sticky flags
//   snap_req                     capture event counters into snapshot regs
//   snap_vld                     one-cycle pulse, snapshot registers updated
//   snap_ld_inst .. snap_st_ack  snapshot values
//   ovf                          sticky overflow {st_ack, st_inst, ld_ack, ld_inst}
//   ld_inflight, st_inflight     outstanding instruction depth
//   inflight_err                 sticky {st, ld} in-flight under/overflow
//   idle                         both in-flight counters are zero
// ---------------------------------------------------------------------------
module pem_counter_bank #(
   parameter int PC_NB    = 2,
   parameter int CNT_W    = 32,
   parameter int INFL_W   = 16,
   parameter int SAT_MODE = 1
) (
   input  logic              clk,
   input  logic              s_rst_n,
   input  logic [PC_NB-1:0]  ld_inst_inc,
   input  logic [PC_NB-1:0]  ld_ack_inc,
   input  logic [PC_NB-1:0]  st_inst_inc,
   input  logic [PC_NB-1:0]  st_ack_inc,
   input  logic              clr,
   input  logic              snap_req,
   output logic              snap_vld,
   output logic [CNT_W-1:0]  snap_ld_inst,
   output logic [CNT_W-1:0]  snap_ld_ack,
   output logic [CNT_W-1:0]  snap_st_inst,
   output logic [CNT_W-1:0]  snap_st_ack,
   output logic [3:0]        ovf,
   output logic [INFL_W-1:0] ld_inflight,
   output logic [INFL_W-1:0] st_inflight,
   output logic [1:0]        inflight_err,
   output logic              idle
);

   localparam int POP_W = $clog2(PC_NB + 1);
   // The in-flight arithmetic carries a few bits of headroom so that the
   // largest possible step (+/- PC_NB) around a full counter never wraps
   // before it is clamped.
   localparam int NW    = INFL_W + 6;

   // Number of channels pulsing in a vector.
   function automatic logic [POP_W-1:0] popcnt(input logic [PC_NB-1:0] v);
      logic [POP_W-1:0] c;
      c = '0;
      for (int i = 0; i < PC_NB; i++) begin
         c = c + POP_W'(v[i]);
      end
      return c;
   endfunction

   // Kinds packed side by side: 0 ld_inst, 1 ld_ack, 2 st_inst, 3 st_ack.
   // This order matches the bit order of ovf.
   logic [4*PC_NB-1:0] inc_all;
   assign inc_all = {st_ack_inc, st_inst_inc, ld_ack_inc, ld_inst_inc};

   genvar k;
   for (k = 0; k < 4; k++) begin : g_evt
      logic [POP_W-1:0] pop;
      logic [CNT_W:0]   sum;
      logic [CNT_W-1:0] live_d;
      logic [CNT_W-1:0] live_q;
      logic [CNT_W-1:0] snap_q;
      logic             ovf_set;
      logic             ovf_q;

      assign pop = popcnt(inc_all[k*PC_NB +: PC_NB]);
      assign sum = {1'b0, live_q} + (CNT_W+1)'(pop);

      // Next live value. A clear restarts the counter from this cycle's
      // increments so nothing arriving alongside the clear is lost; that
      // restart cannot overflow, so overflow only comes from a normal
      // accumulate.
      always_comb begin
         ovf_set = 1'b0;
         live_d  = sum[CNT_W-1:0];
         if (clr) begin
            live_d = CNT_W'(pop);
         end else if (sum[CNT_W]) begin
            ovf_set = 1'b1;
            if (SAT_MODE != 0) begin
               live_d = '1;
            end
         end
      end

      // Live counter, snapshot capture and sticky overflow. The snapshot
      // takes the value before this cycle's increments, so a simultaneous
      // snap+clr hands the old total to software and the new increments
      // to the fresh count.
      always_ff @(posedge clk or negedge s_rst_n) begin
         if (!s_rst_n) begin
            live_q <= '0;
            snap_q <= '0;
            ovf_q  <= 1'b0;
         end else begin
            live_q <= live_d;
            if (snap_req) begin
               snap_q <= live_q;
            end
            ovf_q <= ovf_set | (ovf_q & ~clr);
         end
      end
   end

   assign snap_ld_inst = g_evt[0].snap_q;
   assign snap_ld_ack  = g_evt[1].snap_q;
   assign snap_st_inst = g_evt[2].snap_q;
   assign snap_st_ack  = g_evt[3].snap_q;
   assign ovf          = {g_evt[3].ovf_q, g_evt[2].ovf_q, g_evt[1].ovf_q, g_evt[0].ovf_q};

   genvar j;
   for (j = 0; j < 2; j++) begin : g_infl
      logic [POP_W-1:0]     pop_i;
      logic [POP_W-1:0]     pop_a;
      logic signed [NW-1:0] nxt;
      logic signed [NW-1:0] max_v;
      logic [INFL_W-1:0]    infl_d;
      logic [INFL_W-1:0]    infl_q;
      logic                 err_set;
      logic                 err_q;

      assign pop_i = popcnt(inc_all[(2*j)*PC_NB +: PC_NB]);
      assign pop_a = popcnt(inc_all[(2*j+1)*PC_NB +: PC_NB]);
      assign max_v = $signed({{(NW-INFL_W){1'b0}}, {INFL_W{1'b1}}});
      assign nxt   = $signed({{(NW-INFL_W){1'b0}}, infl_q})
                   + $signed(NW'(pop_i)) - $signed(NW'(pop_a));

      // Clamp the signed depth into range; either clamp flags an error
      // because issue and acknowledge accounting no longer agree.
      always_comb begin
         err_set = 1'b0;
         infl_d  = nxt[INFL_W-1:0];
         if (nxt < 0) begin
            err_set = 1'b1;
            infl_d  = '0;
         end else if (nxt > max_v) begin
            err_set = 1'b1;
            infl_d  = '1;
         end
      end

      // In-flight depth is not touched by clr; only the sticky error is.
      // An error raised in the clearing cycle still sets the flag.
      always_ff @(posedge clk or negedge s_rst_n) begin
         if (!s_rst_n) begin
            infl_q <= '0;
            err_q  <= 1'b0;
         end else begin
            infl_q <= infl_d;
            err_q  <= err_set | (err_q & ~clr);
         end
      end
   end

   assign ld_inflight  = g_infl[0].infl_q;
   assign st_inflight  = g_infl[1].infl_q;
   assign inflight_err = {g_infl[1].err_q, g_infl[0].err_q};

   // Snapshot valid pulse and idle flag, both registered. Idle looks at the
   // next in-flight values so it lines up with the counters it describes.
   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         snap_vld <= 1'b0;
         idle     <= 1'b1;
      end else begin
         snap_vld <= snap_req;
         idle     <= (g_infl[0].infl_d == '0) && (g_infl[1].infl_d == '0);
      end
   end

endmodule
